// File: rtl/uart_tx_fifo_bridge.sv
// Byte FIFO feeding a WISHBONE master that drains it into the MiniUART:
// poll LSR until the transmitter is idle, write the head byte, guard, repeat.
module uart_tx_fifo_bridge #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [2:0]  OFF_DATA   = 3'd0,
   parameter logic [2:0]  OFF_LSR    = 3'd1,
   parameter int unsigned GUARD      = 2,
   parameter int unsigned TS_BIT     = 5
) (
   input  logic                  CLK_I,
   input  logic                  RST_I,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   input  logic                  flush,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ovf,
   output logic                  busy,
   output logic [2:0]            M_ADD_O,
   output logic [31:0]           M_DAT_O,
   input  logic [31:0]           M_DAT_I,
   output logic                  M_STB_O,
   output logic                  M_WE_O,
   input  logic                  M_ACK_I
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
   localparam int unsigned CNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_POLL, ST_SEND, ST_WAIT} state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
   logic [PTR_W-1:0]   wp, rp;
   logic [7:0]         mem [DEPTH];
   logic               push_c, pop_c;
   logic               stb_d, we_d, busy_d;
   logic [2:0]         add_d;
   logic [31:0]        dat_d;
   logic               unused_dat_c;

   assign unused_dat_c = ^M_DAT_I;

   assign empty = (wp == rp);
   assign full  = (wp[PTR_W-1] != rp[PTR_W-1]) &&
                  (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
   assign count = wp - rp;

   // A pop never frees space for a push in the same cycle while full.
   assign push_c = wr_en & ~full & ~flush;
   assign pop_c  = (state == ST_SEND) & M_ACK_I & ~flush;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         wp  <= '0;
         rp  <= '0;
         ovf <= 1'b0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         ovf <= 1'b0;
      end else begin
         if (push_c) wp <= wp + 1'b1;
         if (pop_c)  rp <= rp + 1'b1;
         if (wr_en && full) ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (push_c) mem[wp[DEPTH_LOG2-1:0]] <= wr_data;
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         M_STB_O  <= 1'b0;
         M_WE_O   <= 1'b0;
         M_ADD_O  <= 3'd0;
         M_DAT_O  <= 32'd0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         wait_cnt <= wait_cnt_d;
         M_STB_O  <= stb_d;
         M_WE_O   <= we_d;
         M_ADD_O  <= add_d;
         M_DAT_O  <= dat_d;
         busy     <= busy_d;
      end
   end

   // Next state, plus bus outputs decoded from the next state so they register cleanly.
   always_comb begin
      state_d    = state;
      wait_cnt_d = wait_cnt;
      stb_d      = 1'b0;
      we_d       = 1'b0;
      add_d      = 3'd0;
      dat_d      = 32'd0;

      case (state)
         ST_IDLE: if (!empty && !flush) state_d = ST_POLL;
         ST_POLL: begin
            if (flush)                              state_d = ST_IDLE;
            else if (M_ACK_I && M_DAT_I[TS_BIT])    state_d = ST_SEND;
         end
         ST_SEND: begin
            if (M_ACK_I || flush) begin
               state_d    = ST_WAIT;
               wait_cnt_d = CNT_W'(GUARD - 1);
            end
         end
         ST_WAIT: begin
            if (wait_cnt == '0) state_d = ST_IDLE;
            else                wait_cnt_d = wait_cnt - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_POLL: begin
            stb_d = 1'b1;
            add_d = OFF_LSR;
         end
         ST_SEND: begin
            stb_d = 1'b1;
            we_d  = 1'b1;
            add_d = OFF_DATA;
            dat_d = {24'd0, mem[rp[DEPTH_LOG2-1:0]]};
         end
         default: ;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

endmodule

// File: tb/tb_uart_tx_fifo_bridge.sv
// Directed bench for uart_tx_fifo_bridge against a small MiniUART LSR/DATA model.
module tb_uart_tx_fifo_bridge;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        flush;
   logic        full, empty, ovf, busy;
   logic [4:0]  count;
   logic [2:0]  M_ADD_O;
   logic [31:0] M_DAT_O, M_DAT_I;
   logic        M_STB_O, M_WE_O, M_ACK_I;

   uart_tx_fifo_bridge dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
      .full(full), .empty(empty), .count(count), .ovf(ovf), .busy(busy),
      .M_ADD_O(M_ADD_O), .M_DAT_O(M_DAT_O), .M_DAT_I(M_DAT_I),
      .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .M_ACK_I(M_ACK_I)
   );

   always #5 CLK_I = ~CLK_I;

   int checks = 0;
   int errors = 0;

   // UART model: idle flag drops for 20 cycles after each DATA write when dly_en is set.
   logic        force_busy = 1'b0;
   logic        dly_en = 1'b0;
   int          dly_cnt;
   logic        seen_idle;
   logic        lsr_bit;
   logic [31:0] wr_log [$];

   assign lsr_bit = !force_busy && (dly_cnt == 0);
   assign M_DAT_I = {26'd0, lsr_bit, 5'd0};
   assign M_ACK_I = M_STB_O;

   always @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         dly_cnt   <= 0;
         seen_idle <= 1'b0;
      end else begin
         if (M_STB_O && !M_WE_O && M_ACK_I && lsr_bit) seen_idle <= 1'b1;
         if (M_STB_O && M_WE_O && M_ACK_I) begin
            wr_log.push_back(M_DAT_O);
            checks++;
            if (!seen_idle || !lsr_bit || M_ADD_O != 3'd0) begin
               errors++;
               $display("FAIL write_guard: seen_idle=%0b lsr=%0b add=%0d want 1 1 0",
                        seen_idle, lsr_bit, M_ADD_O);
            end
            seen_idle <= 1'b0;
            if (dly_en) dly_cnt <= 20;
         end else if (dly_cnt > 0) begin
            dly_cnt <= dly_cnt - 1;
         end
      end
   end

   task automatic step();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input int bound);
      bit done;
      done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         if (empty && !busy) done = 1'b1;
         else step();
      end
      chk("drain_timeout", {63'd0, done}, 64'd1);
   endtask

   task automatic push(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      step();
      wr_en   = 1'b0;
   endtask

   typedef struct {
      logic        wr_en;
      logic [7:0]  wr_data;
      logic        flush;
      logic        lsr_idle;
      logic [4:0]  cnt;
      logic        empty, full, ovf, busy, stb, we;
      logic [2:0]  add;
      logic [31:0] dat;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_I = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
      repeat (2) step();
      chk("reset_state", {count, empty, full, ovf, busy, M_STB_O, M_WE_O, M_ADD_O, M_DAT_O},
          {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0});
      RST_I = 1'b0;
      step();

      // Single byte with idle UART, then a flush out of POLL with wr_en ignored.
      tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 32'h41};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
      tbl[6] = '{1'b1, 8'h50, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
      tbl[7] = '{1'b1, 8'h51, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0};
      tbl[8] = '{1'b1, 8'h52, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
      tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};

      wr_log.delete();
      for (int i = 0; i < 10; i++) begin
         wr_en      = tbl[i].wr_en;
         wr_data    = tbl[i].wr_data;
         flush      = tbl[i].flush;
         force_busy = !tbl[i].lsr_idle;
         step();
         chk($sformatf("vec%0d", i),
             {count, empty, full, ovf, busy, M_STB_O, M_WE_O, M_ADD_O, M_DAT_O},
             {tbl[i].cnt, tbl[i].empty, tbl[i].full, tbl[i].ovf, tbl[i].busy,
              tbl[i].stb, tbl[i].we, tbl[i].add, tbl[i].dat});
      end
      wr_en = 1'b0; flush = 1'b0; force_busy = 1'b0;
      chk("vec_writes", {32'd0, 32'(wr_log.size())}, 64'd1);
      chk("vec_wdata", {32'd0, wr_log[0]}, 64'h41);

      // LSR busy for 100 cycles: POLL held steady, write follows within 2 cycles of release.
      wr_log.delete();
      force_busy = 1'b1;
      push(8'h77);
      step();
      for (int i = 0; i < 100; i++) begin
         chk("poll_hold", {59'd0, M_STB_O, M_WE_O, M_ADD_O}, {59'd0, 1'b1, 1'b0, 3'd1});
         step();
      end
      chk("poll_no_write", {32'd0, 32'(wr_log.size())}, 64'd0);
      force_busy = 1'b0;
      step();
      step();
      chk("poll_release_write", {32'd0, 32'(wr_log.size())}, 64'd1);
      chk("poll_release_data", {32'd0, wr_log[0]}, 64'h77);
      wait_idle(50);

      // UART busy for 20 cycles after each write.
      wr_log.delete();
      dly_en = 1'b1;
      push(8'h41); push(8'h42); push(8'h43);
      wait_idle(300);
      dly_en = 1'b0;
      repeat (25) step();
      chk("dly_writes", {32'd0, 32'(wr_log.size())}, 64'd3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("dly_data%0d", i), {32'd0, wr_log[i]}, 64'(32'h41 + i));

      // Overflow: 17 pushes into a 16-deep FIFO with the UART stalled.
      wr_log.delete();
      force_busy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         push(8'(8'h60 + i));
         if (i == 15) chk("full16", {58'd0, full, count, ovf}, {58'd0, 1'b1, 5'd16, 1'b0});
      end
      chk("ovf17", {58'd0, full, count, ovf}, {58'd0, 1'b1, 5'd16, 1'b1});
      force_busy = 1'b0;
      wait_idle(300);
      chk("ovf_writes", {32'd0, 32'(wr_log.size())}, 64'd16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("ovf_data%0d", i), {32'd0, wr_log[i]}, 64'(32'h60 + i));
      chk("ovf_sticky", {63'd0, ovf}, 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("ovf_flush_clear", {63'd0, ovf}, 64'd0);

      // Push coinciding with a SEND pop at count=3.
      wr_log.delete();
      force_busy = 1'b1;
      push(8'hA0); push(8'hA1); push(8'hA2);
      force_busy = 1'b0;
      step();
      chk("pp_send", {58'd0, M_WE_O, count}, {58'd0, 1'b1, 5'd3});
      push(8'hA3);
      chk("pp_count", {59'd0, count}, 64'd3);
      wait_idle(100);
      chk("pp_writes", {32'd0, 32'(wr_log.size())}, 64'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("pp_data%0d", i), {32'd0, wr_log[i]}, 64'(32'hA0 + i));

      // Flush during SEND with 5 bytes queued.
      wr_log.delete();
      force_busy = 1'b1;
      for (int i = 0; i < 5; i++) push(8'(8'hB0 + i));
      force_busy = 1'b0;
      step();
      chk("fl_send", {58'd0, M_STB_O, M_WE_O, count[3:0]}, {58'd0, 1'b1, 1'b1, 4'd5});
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_after", {53'd0, 32'(wr_log.size()), count, empty, ovf, M_STB_O, busy},
          {53'd0, 32'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1});
      chk("fl_data", {32'd0, wr_log[0]}, 64'hB0);
      step();
      chk("fl_guard1", {63'd0, busy}, 64'd1);
      step();
      chk("fl_guard2", {63'd0, busy}, 64'd0);
      repeat (10) step();
      chk("fl_quiet", {31'd0, 32'(wr_log.size()), M_STB_O}, {31'd0, 32'd1, 1'b0});

      // Asynchronous reset in the middle of SEND.
      wr_log.delete();
      force_busy = 1'b1;
      push(8'hC5);
      step();
      force_busy = 1'b0;
      step();
      chk("rst_send", {62'd0, M_STB_O, M_WE_O}, {62'd0, 1'b1, 1'b1});
      RST_I = 1'b1;
      #1;
      chk("rst_async", {count, empty, full, ovf, busy, M_STB_O, M_WE_O, M_ADD_O, M_DAT_O},
          {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0});
      step();
      RST_I = 1'b0;
      repeat (10) step();
      chk("rst_no_write", {30'd0, 32'(wr_log.size()), M_STB_O, busy}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
